sext_pipe: RTL and testbench

SEXT_PIPE -- requirements
Module: sext_pipe

---
 rtl/sext_pkg.sv | 13 +
 rtl/sext_core.sv | 19 +
 rtl/sext_pipe.sv | 69 ++++++
 tb/tb_sext_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sext_pkg.sv
// sext_pkg: field-width defaults, sel encoding and the shared extension helper
package sext_pkg;
   localparam int FW0_D = 11;
   localparam int FW1_D = 9;
   localparam int FW2_D = 6;
   localparam int FW3_D = 5;
   typedef enum logic [1:0] {SEL_0, SEL_1, SEL_2, SEL_3} sel_t;
   function automatic logic [63:0] sext_fn(input logic [63:0] v, input int f, input logic z);
      logic [63:0] m;
      m = (f >= 64) ? '1 : (64'd1 << f) - 64'd1;
      return (v & m) | ((!z && v[6'(f - 1)]) ? ~m : 64'd0);
   endfunction
endpackage

// File: rtl/sext_core.sv
// sext_core: combinational sign/zero extension of the captured field
module sext_core import sext_pkg::*; #(
   parameter int W = 16,
   parameter int FW0 = FW0_D,
   parameter int FW1 = FW1_D,
   parameter int FW2 = FW2_D,
   parameter int FW3 = FW3_D
) (
   input  logic [W-1:0] field,
   input  sel_t         sel,
   input  logic         zext,
   output logic [W-1:0] res
);
   int fw;
   always_comb begin
      fw = (sel == SEL_0) ? FW0 : (sel == SEL_1) ? FW1 : (sel == SEL_2) ? FW2 : FW3;
      res = W'(sext_fn(64'(field), fw, zext));
   end
endmodule

// File: rtl/sext_pipe.sv
// sext_pipe: two-stage valid/ready pipeline extending a selectable IR field
module sext_pipe import sext_pkg::*; #(
   parameter int W = 16,
   parameter int FW0 = FW0_D,
   parameter int FW1 = FW1_D,
   parameter int FW2 = FW2_D,
   parameter int FW3 = FW3_D
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] IR,
   input  logic [1:0]   sel,
   input  logic         zext,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   if (W < 1 || W > 64) begin : g_w_chk
      $error("sext_pipe: W must lie in 1..64");
   end
   if (FW0 < 1 || FW0 > W || FW1 < 1 || FW1 > W || FW2 < 1 || FW2 > W || FW3 < 1 || FW3 > W) begin : g_fw_chk
      $error("sext_pipe: every FWk must lie in 1..W");
   end
   logic s1_v, s2_v, s1_zext, adv, in_x, out_x;
   sel_t s1_sel;
   logic [W-1:0] s1_field, res;
   int fw_in;
   always_comb begin
      fw_in = (sel == 2'd0) ? FW0 : (sel == 2'd1) ? FW1 : (sel == 2'd2) ? FW2 : FW3;
      out_x = s2_v & out_ready;
      adv = s1_v & (~s2_v | out_x);
      in_ready = ~Reset & ~flush & (~s1_v | adv);
      in_x = in_valid & in_ready;
   end
   assign out_valid = s2_v;
   assign count = 2'(s1_v) + 2'(s2_v);
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         dout <= '0;
      end else if (flush) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= in_x | (s1_v & ~adv);
         s2_v <= adv | (s2_v & ~out_x);
         if (adv) dout <= res;
      end
   end
   // S1 holds only the selected field, upper bits cleared
   always_ff @(posedge Clk) begin
      if (in_x) begin
         s1_field <= W'(sext_fn(64'(IR), fw_in, 1'b1));
         s1_sel <= sel_t'(sel);
         s1_zext <= zext;
      end
   end
   sext_core #(.W(W), .FW0(FW0), .FW1(FW1), .FW2(FW2), .FW3(FW3)) u_core (
      .field(s1_field),
      .sel(s1_sel),
      .zext(s1_zext),
      .res(res)
   );
endmodule

// File: tb/tb_sext_pipe.sv
// tb_sext_pipe: table-driven and scenario checks for sext_pipe (W=16)
module tb_sext_pipe;
   logic Clk = 1'b0, Reset = 1'b1, flush = 1'b0, in_valid = 1'b0, zext = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid;
   logic [15:0] IR = '0, dout;
   logic [1:0] sel = '0, count;
   int pass_n = 0, tot_n = 0;
   typedef struct {
      logic [15:0] ir;
      logic [1:0]  sel;
      logic        z;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[9];
   logic [15:0] exp_q[$];
   sext_pipe dut (
      .Clk(Clk), .Reset(Reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .IR(IR), .sel(sel), .zext(zext), .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .count(count)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   function automatic logic [15:0] ref_ext(input logic [15:0] ir, input logic [1:0] s, input logic z);
      int f;
      logic [15:0] r;
      f = (s == 2'd0) ? 11 : (s == 2'd1) ? 9 : (s == 2'd2) ? 6 : 5;
      for (int i = 0; i < 16; i++) r[i] = (i < f) ? ir[i] : (z ? 1'b0 : ir[f-1]);
      return r;
   endfunction
   task automatic send(input logic [15:0] ir, input logic [1:0] s, input logic z);
      in_valid = 1'b1; IR = ir; sel = s; zext = z;
      @(negedge Clk);
      in_valid = 1'b0; sel = ~s; zext = ~z;
   endtask
   task automatic apply_vec(input vec_t v, input int idx);
      out_ready = 1'b1;
      send(v.ir, v.sel, v.z);
      #1 chk($sformatf("vec%0d_lat1_valid", idx), out_valid, 0);
      chk($sformatf("vec%0d_count", idx), count, 1);
      @(negedge Clk);
      #1 chk($sformatf("vec%0d_valid", idx), out_valid, 1);
      chk($sformatf("vec%0d_dout", idx), dout, v.exp);
      @(negedge Clk);
      #1 chk($sformatf("vec%0d_drain", idx), count, 0);
   endtask
   initial begin
      logic [15:0] ea, eb, ec, hold_d, e;
      logic hold_v;
      int sent, got, cyc;
      vecs[0] = '{16'h0400, 2'd0, 1'b0, 16'hFC00};
      vecs[1] = '{16'h01FF, 2'd1, 1'b0, 16'hFFFF};
      vecs[2] = '{16'h0020, 2'd2, 1'b0, 16'hFFE0};
      vecs[3] = '{16'h0020, 2'd2, 1'b1, 16'h0020};
      vecs[4] = '{16'hFFEF, 2'd3, 1'b1, 16'h000F};
      vecs[5] = '{16'hFFEF, 2'd3, 1'b0, 16'h000F};
      vecs[6] = '{16'h03FF, 2'd0, 1'b0, 16'h03FF};
      vecs[7] = '{16'hABCD, 2'd1, 1'b1, 16'h01CD};
      vecs[8] = '{16'h8010, 2'd3, 1'b0, 16'hFFF0};
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_dout", dout, 0);
      @(negedge Clk);
      Reset = 1'b0;
      #1 chk("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);
      // backpressure: two accepted, third stalls, then in-order drain
      ea = 16'hFC00; eb = 16'hFFFF; ec = 16'h0020;
      out_ready = 1'b0;
      in_valid = 1'b1; IR = 16'h0400; sel = 2'd0; zext = 1'b0;
      @(negedge Clk);
      IR = 16'h01FF; sel = 2'd1;
      @(negedge Clk);
      IR = 16'h0020; sel = 2'd2; zext = 1'b1;
      #1 chk("bp_count2", count, 2);
      chk("bp_in_ready0", in_ready, 0);
      @(negedge Clk);
      #1 chk("bp_hold_dout", dout, ea);
      chk("bp_still_blocked", in_ready, 0);
      out_ready = 1'b1;
      #1 chk("bp_in_ready_on_drain", in_ready, 1);
      chk("bp_res0", dout, ea);
      @(negedge Clk);
      in_valid = 1'b0;
      #1 chk("bp_res1_valid", out_valid, 1);
      chk("bp_res1", dout, eb);
      @(negedge Clk);
      #1 chk("bp_res2_valid", out_valid, 1);
      chk("bp_res2", dout, ec);
      @(negedge Clk);
      #1 chk("bp_empty_valid", out_valid, 0);
      chk("bp_empty_count", count, 0);
      // random streaming with scoreboard and stall-stability checks
      sent = 0; got = 0; cyc = 0; hold_v = 1'b0; hold_d = '0;
      while (got < 100 && cyc < 3000) begin
         in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
         IR = 16'($urandom);
         sel = 2'($urandom_range(0, 3));
         zext = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (hold_v) chk("stream_stable", dout, hold_d);
         if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk($sformatf("stream_res%0d", got), dout, e);
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_ext(IR, sel, zext));
            sent++;
         end
         hold_v = out_valid && !out_ready;
         hold_d = dout;
         @(negedge Clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_received", got, 100);
      out_ready = 1'b1;
      @(negedge Clk);
      #1 chk("stream_drained", count, 0);
      // flush beats a simultaneous offer
      out_ready = 1'b0;
      send(16'h0400, 2'd0, 1'b0);
      send(16'h01FF, 2'd1, 1'b0);
      #1 chk("fl_full", count, 2);
      flush = 1'b1; in_valid = 1'b1; IR = 16'h7777; sel = 2'd0; zext = 1'b0;
      #1 chk("fl_in_ready0", in_ready, 0);
      @(negedge Clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1 chk("fl_out_valid", out_valid, 0);
      chk("fl_count", count, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         #1 chk($sformatf("fl_no_ghost%0d", i), out_valid, 0);
      end
      apply_vec(vecs[2], 100);
      // asynchronous reset mid-operation
      out_ready = 1'b0;
      send(16'h0400, 2'd0, 1'b0);
      send(16'h01FF, 2'd1, 1'b0);
      #1 chk("ar_full", count, 2);
      #1 Reset = 1'b1;
      #1 chk("ar_out_valid", out_valid, 0);
      chk("ar_count", count, 0);
      chk("ar_dout", dout, 0);
      chk("ar_in_ready", in_ready, 0);
      #1 Reset = 1'b0;
      @(negedge Clk);
      out_ready = 1'b1;
      #1 chk("ar_ready_after", in_ready, 1);
      chk("ar_no_old_valid", out_valid, 0);
      apply_vec(vecs[8], 200);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
